// File: rtl/axis_frame_gen_if.sv
// axistream_if: AXI-Stream bundle used between frame sources and sinks.
//   tdata/tkeep/tstrb/tlast/tvalid/tid/tdest/tuser  master -> slave
//   tready                                            slave -> master
// Parameters: DATA_WIDTH (multiple of 8), ID_WIDTH, DEST_WIDTH, USER_WIDTH.
interface axistream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream counter-pattern frame source.
//   s_aclk      clock
//   s_areset    synchronous active-high reset
//   start       single-cycle request, honoured only while idle
//   continuous  keep repeating the latched frame (sampled at each frame end)
//   frame_len   frame length in bytes (latched on an accepted start)
//   gap_cycles  idle cycles between continuous frames (latched on start)
//   seed        tdata of the first beat of every frame (latched on start)
//   busy        high whenever not idle
//   frame_cnt   completed-frame counter, wraps modulo 2^32
//   m_axis      AXI-Stream master; beat k carries seed + k
// All outputs come straight from registers; tvalid never depends on tready.
module axis_frame_gen #(
    parameter type TDATA_TYPE = logic [31:0],
    parameter int  LEN_WIDTH  = 16,
    parameter int  GAP_WIDTH  = 8,
    localparam int DATA_WIDTH = $bits(TDATA_TYPE),
    localparam int BYTES_NUM  = DATA_WIDTH / 8
) (
    input  logic                  s_aclk,
    input  logic                  s_areset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic [31:0]           frame_cnt,
    axistream_if.master           m_axis
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic [31:0]           frame_cnt_q, frame_cnt_d;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BYTES_NUM-1:0]  keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;

    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  last_idx_q, last_idx_d;
    logic [BYTES_NUM-1:0]  last_keep_q, last_keep_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;

    // Frame geometry derived from the live frame_len input; only used on
    // the cycle a start is accepted, then held in last_idx_q/last_keep_q.
    logic [LEN_WIDTH-1:0]  start_last_idx;
    logic [LEN_WIDTH-1:0]  start_rem;
    logic [BYTES_NUM-1:0]  start_last_keep;
    logic                  start_one_beat;

    // First beat of a repeated frame, from the latched geometry.
    logic                  rep_one_beat;
    logic [BYTES_NUM-1:0]  rep_first_keep;

    always_comb begin
        start_last_idx = (frame_len - 1'b1) / LEN_WIDTH'(BYTES_NUM);
        start_rem      = frame_len % LEN_WIDTH'(BYTES_NUM);
        start_one_beat = (start_last_idx == '0);
        start_last_keep = '0;
        for (int unsigned i = 0; i < BYTES_NUM; i++) begin
            start_last_keep[i] = (start_rem == '0) || (LEN_WIDTH'(i) < start_rem);
        end
    end

    always_comb begin
        rep_one_beat   = (last_idx_q == '0);
        rep_first_keep = rep_one_beat ? last_keep_q : '1;
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            data_q      <= '0;
            keep_q      <= '1;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            beat_q      <= '0;
            last_idx_q  <= '0;
            last_keep_q <= '1;
            gap_q       <= '0;
            seed_q      <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            beat_q      <= beat_d;
            last_idx_q  <= last_idx_d;
            last_keep_q <= last_keep_d;
            gap_q       <= gap_d;
            seed_q      <= seed_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so the final handshake can load the first beat of the
    // following frame directly (no bubble when gap is zero).
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        data_d      = data_q;
        keep_d      = keep_q;
        last_d      = last_q;
        valid_d     = valid_q;
        beat_d      = beat_q;
        last_idx_d  = last_idx_q;
        last_keep_d = last_keep_q;
        gap_d       = gap_q;
        seed_d      = seed_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_d     = SEND;
                    busy_d      = 1'b1;
                    last_idx_d  = start_last_idx;
                    last_keep_d = start_last_keep;
                    gap_d       = gap_cycles;
                    seed_d      = seed;
                    beat_d      = '0;
                    valid_d     = 1'b1;
                    data_d      = seed;
                    last_d      = start_one_beat;
                    keep_d      = start_one_beat ? start_last_keep : '1;
                end
            end

            SEND: begin
                if (valid_q && m_axis.tready) begin
                    if (last_q) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        if (!continuous) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end else if (gap_q == '0) begin
                            beat_d  = '0;
                            data_d  = seed_q;
                            valid_d = 1'b1;
                            last_d  = rep_one_beat;
                            keep_d  = rep_first_keep;
                        end else begin
                            state_d   = GAP;
                            valid_d   = 1'b0;
                            last_d    = 1'b0;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                        data_d = data_q + 1'b1;
                        last_d = ((beat_q + 1'b1) == last_idx_q);
                        keep_d = ((beat_q + 1'b1) == last_idx_q) ? last_keep_q : '1;
                    end
                end
            end

            GAP: begin
                // The first beat is loaded on the gap-th edge so that exactly
                // gap cycles with tvalid low separate the two frames.
                if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    state_d = SEND;
                    beat_d  = '0;
                    data_d  = seed_q;
                    valid_d = 1'b1;
                    last_d  = rep_one_beat;
                    keep_d  = rep_first_keep;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tstrb  = '1;
    assign m_axis.tlast  = last_q;
    assign m_axis.tvalid = valid_q;
    assign m_axis.tid    = '0;
    assign m_axis.tdest  = '0;
    assign m_axis.tuser  = '0;

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;
    localparam int DW = 32;
    localparam int BN = DW / 8;
    localparam int LW = 16;
    localparam int GW = 8;

    logic          s_aclk;
    logic          s_areset;
    logic          start;
    logic          continuous;
    logic [LW-1:0] frame_len;
    logic [GW-1:0] gap_cycles;
    logic [DW-1:0] seed;
    logic          busy;
    logic [31:0]   frame_cnt;

    axistream_if #(.DATA_WIDTH(DW)) axis ();

    axis_frame_gen #(
        .TDATA_TYPE(logic [31:0]),
        .LEN_WIDTH (LW),
        .GAP_WIDTH (GW)
    ) dut (
        .s_aclk    (s_aclk),
        .s_areset  (s_areset),
        .start     (start),
        .continuous(continuous),
        .frame_len (frame_len),
        .gap_cycles(gap_cycles),
        .seed      (seed),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .m_axis    (axis)
    );

    initial begin
        s_aclk = 1'b0;
        forever #5 s_aclk = ~s_aclk;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [BN-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic valid;
        logic xfer;
        logic last;
    } cyc_t;

    int     nassert = 0;
    int     nfail   = 0;
    beat_t  got[$];
    cyc_t   hist[$];
    logic   rec_en  = 1'b0;
    logic   rdy_rand = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfer monitor: a beat counts when tvalid&&tready is seen at the
    // falling edge (inputs do not change before the next rising edge).
    beat_t held;
    logic  held_v = 1'b0;
    always @(negedge s_aclk) begin
        if (s_areset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", 64'(axis.tvalid), 64'(1));
                chk("hold_beat", 64'({axis.tdata, axis.tkeep, axis.tlast}),
                    64'({held.data, held.keep, held.last}));
            end
            if (rec_en)
                hist.push_back('{axis.tvalid, axis.tvalid && axis.tready, axis.tlast});
            if (axis.tvalid && axis.tready)
                got.push_back('{axis.tdata, axis.tkeep, axis.tlast});
            held_v = axis.tvalid && !axis.tready;
            held   = '{axis.tdata, axis.tkeep, axis.tlast};
        end
    end

    task automatic tick();
        @(posedge s_aclk);
        #1;
        if (rdy_rand) axis.tready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_idle_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_lasts(input string tag, input int want, input int budget);
        int n = 0;
        while (count_lasts() < want && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_frames_timeout"}, 64'(count_lasts() >= want), 64'(1));
    endtask

    function automatic int count_lasts();
        int c = 0;
        foreach (got[i]) if (got[i].last) c++;
        return c;
    endfunction

    // Reference: nfr repetitions of a frame of len bytes starting at sd.
    task automatic compare_frames(input string tag, input int len, input logic [DW-1:0] sd,
                                  input int nfr);
        beat_t exp_q[$];
        int beats = (len + BN - 1) / BN;
        int rem   = len % BN;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < beats; k++) begin
                beat_t b;
                b.data = sd + DW'(k);
                b.last = (k == beats - 1);
                b.keep = (b.last && rem != 0) ? BN'((1 << rem) - 1) : '1;
                exp_q.push_back(b);
            end
        end
        chk({tag, "_beats"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(got[i].data), 64'(exp_q[i].data));
            chk($sformatf("%s_keep%0d", tag, i), 64'(got[i].keep), 64'(exp_q[i].keep));
            chk($sformatf("%s_last%0d", tag, i), 64'(got[i].last), 64'(exp_q[i].last));
        end
    endtask

    // Between a final transfer and the next tvalid there must be exactly gap
    // cycles with tvalid low.
    task automatic check_gaps(input string tag, input int gap);
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].xfer && hist[i].last) begin
                int run = 0;
                while (i + 1 + run < hist.size() && !hist[i + 1 + run].valid) run++;
                if (i + 1 + run < hist.size())
                    chk($sformatf("%s_gap@%0d", tag, i), 64'(run), 64'(gap));
            end
        end
    endtask

    initial begin
        int            fc0;
        int            nl;
        int            len;
        int            gap;
        logic [DW-1:0] sd;

        s_areset    = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        frame_len   = '0;
        gap_cycles  = '0;
        seed        = '0;
        axis.tready = 1'b1;

        // Reset values
        repeat (3) tick();
        s_areset = 1'b0;
        @(negedge s_aclk);
        chk("rst_tvalid", 64'(axis.tvalid), 64'(0));
        chk("rst_tlast", 64'(axis.tlast), 64'(0));
        chk("rst_tdata", 64'(axis.tdata), 64'(0));
        chk("rst_tkeep", 64'(axis.tkeep), 64'(4'hF));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        tick();

        // Single 10-byte frame, full throughput, latency 1
        got.delete();
        frame_len = 16'd10;
        seed      = 32'h100;
        start     = 1'b1;
        @(negedge s_aclk);
        chk("t1_valid_before", 64'(axis.tvalid), 64'(0));
        tick();
        start = 1'b0;
        @(negedge s_aclk);
        chk("t1_valid_lat1", 64'(axis.tvalid), 64'(1));
        chk("t1_busy", 64'(busy), 64'(1));
        wait_idle("t1", 50);
        compare_frames("t1", 10, 32'h100, 1);
        chk("t1_frame_cnt", 64'(frame_cnt), 64'(1));
        chk("t1_tvalid_end", 64'(axis.tvalid), 64'(0));

        // Same frame under random backpressure
        got.delete();
        rdy_rand = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t2", 200);
        compare_frames("t2", 10, 32'h100, 1);
        chk("t2_frame_cnt", 64'(frame_cnt), 64'(2));
        rdy_rand    = 1'b0;
        axis.tready = 1'b1;

        // Continuous, gap 0: back-to-back 2-beat frames
        got.delete();
        hist.delete();
        fc0        = frame_cnt;
        rec_en     = 1'b1;
        frame_len  = 16'd8;
        gap_cycles = 8'd0;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_lasts("t3", 50, 400);
        nl         = count_lasts();
        continuous = 1'b0;
        wait_idle("t3", 50);
        rec_en = 1'b0;
        compare_frames("t3", 8, 32'h100, nl + 1);
        chk("t3_frame_cnt", 64'(frame_cnt - fc0), 64'(nl + 1));
        check_gaps("t3", 0);

        // Continuous 1-byte frames with a 3-cycle gap
        got.delete();
        hist.delete();
        fc0        = frame_cnt;
        rec_en     = 1'b1;
        frame_len  = 16'd1;
        gap_cycles = 8'd3;
        seed       = 32'hFFFF_FFFE;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_lasts("t4", 4, 100);
        nl         = count_lasts();
        continuous = 1'b0;
        wait_idle("t4", 50);
        rec_en = 1'b0;
        compare_frames("t4", 1, 32'hFFFF_FFFE, nl + 1);
        chk("t4_frame_cnt", 64'(frame_cnt - fc0), 64'(nl + 1));
        check_gaps("t4", 3);

        // Randomized continuous runs with backpressure; inputs changed
        // while busy must not affect the latched frame.
        for (int r = 0; r < 5; r++) begin
            got.delete();
            hist.delete();
            len        = int'($urandom_range(1, 21));
            gap        = int'($urandom_range(0, 4));
            sd         = $urandom;
            fc0        = frame_cnt;
            rec_en     = 1'b1;
            rdy_rand   = 1'b1;
            frame_len  = LW'(len);
            gap_cycles = GW'(gap);
            seed       = sd;
            continuous = 1'b1;
            start      = 1'b1;
            tick();
            start      = 1'b0;
            frame_len  = LW'($urandom_range(1, 60));
            gap_cycles = GW'($urandom_range(0, 9));
            seed       = $urandom;
            wait_lasts("t5", 2, 600);
            nl         = count_lasts();
            continuous = 1'b0;
            wait_idle("t5", 300);
            rec_en = 1'b0;
            compare_frames($sformatf("t5r%0d", r), len, sd, nl + 1);
            chk("t5_frame_cnt", 64'(frame_cnt - fc0), 64'(nl + 1));
            check_gaps("t5", gap);
        end
        rdy_rand    = 1'b0;
        axis.tready = 1'b1;

        // Start with zero length is ignored
        got.delete();
        fc0       = frame_cnt;
        frame_len = '0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) begin
            @(negedge s_aclk);
            chk("t6_busy", 64'(busy), 64'(0));
            chk("t6_tvalid", 64'(axis.tvalid), 64'(0));
            tick();
        end
        chk("t6_frame_cnt", 64'(frame_cnt), 64'(fc0));

        // Start while busy does not disturb the in-flight frame
        got.delete();
        axis.tready = 1'b0;
        frame_len   = 16'd12;
        seed        = 32'h55;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t7_busy", 64'(busy), 64'(1));
        frame_len   = 16'd40;
        seed        = 32'hAAAA;
        start       = 1'b1;
        axis.tready = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t7", 50);
        compare_frames("t7", 12, 32'h55, 1);

        // Reset while beat 2 of 5 is presented
        got.delete();
        frame_len = 16'd20;
        seed      = 32'h7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t8_beat2_data", 64'(axis.tdata), 64'(32'h8));
        s_areset    = 1'b1;
        axis.tready = 1'b0;
        tick();
        s_areset = 1'b0;
        @(negedge s_aclk);
        chk("t8_rst_tvalid", 64'(axis.tvalid), 64'(0));
        chk("t8_rst_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("t8_rst_busy", 64'(busy), 64'(0));
        tick();
        got.delete();
        axis.tready = 1'b1;
        seed        = 32'h9;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t8", 50);
        compare_frames("t8", 20, 32'h9, 1);
        chk("t8_frame_cnt", 64'(frame_cnt), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
